rice_core_ex_buffer: RTL and testbench

- Two-entry elastic buffer directly downstream of the ALU in the execute stage.
- Captures each executed instruction's ALU result, destination register and write enable, then hands them to the memory/writeback stage over a valid/ready handshake.
- Decouples ALU timing from downstream stalls.
- Provides a combinational bypass lookup so decode can forward not-yet-retired results.

---
 rtl/rice_core_ex_buffer.sv | 156 +++++++++++++++
 tb/tb_rice_core_ex_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_core_ex_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rice_core_ex_buffer
// Description : Two-entry elastic FIFO between the ALU and the memory /
//               writeback stage. Registers each executed instruction's
//               {result, rd, rd_write} and presents the oldest entry over a
//               valid/ready handshake. A combinational bypass port lets
//               decode find the youngest buffered writer of a source
//               register.
//
// Ports       : i_clk, i_rst            clock, async active-high reset
//               i_flush                 kill buffered entries and this
//                                       cycle's input
//               i_valid / o_ready       upstream handshake (ALU side)
//               i_result, i_rd,
//               i_rd_write              incoming entry payload
//               o_valid / i_ready       downstream handshake (MEM/WB side)
//               o_result, o_rd,
//               o_rd_write              head entry payload
//               i_lookup_rs             source register queried by decode
//               o_lookup_hit,
//               o_lookup_value          bypass result
//
// Revision    : 1.0 - initial release
// ============================================================================
module rice_core_ex_buffer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_result,
    input  logic [4:0]      i_rd,
    input  logic            i_rd_write,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_rd_write,
    input  logic [4:0]      i_lookup_rs,
    output logic            o_lookup_hit,
    output logic [XLEN-1:0] o_lookup_value
);

    localparam logic [1:0] c_full = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            count_q, count_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0][XLEN-1:0]  result_q, result_d;
    logic [1:0][4:0]       rd_q, rd_d;
    logic [1:0]            rd_write_q, rd_write_d;

    logic                  w_push;
    logic                  w_pop;

    // Handshake flags come only from the registered count, so o_ready has
    // no combinational dependence on i_ready.
    assign o_ready = (count_q != c_full);
    assign o_valid = (count_q != 2'd0);

    assign w_push = i_valid & o_ready & ~i_flush;
    assign w_pop  = o_valid & i_ready & ~i_flush;

    assign o_result   = result_q[rptr_q];
    assign o_rd       = rd_q[rptr_q];
    assign o_rd_write = rd_write_q[rptr_q];

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        result_d   = result_q;
        rd_d       = rd_q;
        rd_write_d = rd_write_q;

        if (i_flush) begin
            // Payload is left in place; with count=0 it is never observed.
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (w_push) begin
                result_d[wptr_q]   = i_result;
                rd_d[wptr_q]       = i_rd;
                rd_write_d[wptr_q] = i_rd_write;
                wptr_d             = ~wptr_q;
            end
            if (w_pop) begin
                rptr_d = ~rptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q    <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            result_q   <= '0;
            rd_q       <= '0;
            rd_write_q <= '0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            rd_write_q <= rd_write_d;
        end
    end

    // ------------------------------------------------------------------
    // Bypass lookup
    // ------------------------------------------------------------------
    // With one entry it sits at rptr; with two both slots are live. The
    // younger slot is always wptr-1, which for a 1-bit pointer is ~wptr.
    logic [1:0] w_entry_valid;
    logic [1:0] w_cand;
    logic       w_young;

    always_comb begin
        w_young        = ~wptr_q;
        o_lookup_hit   = 1'b0;
        o_lookup_value = '0;
        for (int i = 0; i < 2; i++) begin
            w_entry_valid[i] = (count_q == c_full) ||
                               ((count_q == 2'd1) && (rptr_q == 1'(i)));
            w_cand[i]        = w_entry_valid[i] && rd_write_q[i] &&
                               (rd_q[i] == i_lookup_rs) &&
                               (i_lookup_rs != 5'd0);
        end
        if (w_cand[w_young]) begin
            o_lookup_hit   = 1'b1;
            o_lookup_value = result_q[w_young];
        end else if (w_cand[~w_young]) begin
            o_lookup_hit   = 1'b1;
            o_lookup_value = result_q[~w_young];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rice_core_ex_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rice_core_ex_buffer
// Description : Directed testbench for rice_core_ex_buffer. A queue-based
//               reference model is compared against the DUT every cycle,
//               and literal expectations pin key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rice_core_ex_buffer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            out_ready;
    logic [XLEN-1:0] in_result;
    logic [4:0]      in_rd;
    logic            in_rd_write;
    logic            out_valid;
    logic            in_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_rd_write;
    logic [4:0]      lookup_rs;
    logic            lookup_hit;
    logic [XLEN-1:0] lookup_value;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            wr;
    } ent_t;

    ent_t mq[$];

    always #5 clk = ~clk;

    rice_core_ex_buffer #(.XLEN(XLEN)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_valid        (in_valid),
        .o_ready        (out_ready),
        .i_result       (in_result),
        .i_rd           (in_rd),
        .i_rd_write     (in_rd_write),
        .o_valid        (out_valid),
        .i_ready        (in_ready),
        .o_result       (out_result),
        .o_rd           (out_rd),
        .o_rd_write     (out_rd_write),
        .i_lookup_rs    (lookup_rs),
        .o_lookup_hit   (lookup_hit),
        .o_lookup_value (lookup_value)
    );

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model lookup: scan from youngest to oldest.
    task automatic model_lookup(output logic hit, output logic [XLEN-1:0] val);
        hit = 1'b0;
        val = '0;
        for (int k = mq.size() - 1; k >= 0; k--) begin
            if (!hit && mq[k].wr && mq[k].rd == lookup_rs && lookup_rs != 5'd0) begin
                hit = 1'b1;
                val = mq[k].result;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic            m_hit;
        logic [XLEN-1:0] m_val;
        if (!rst) begin
            check("o_valid", 32'(out_valid), 32'(mq.size() != 0));
            check("o_ready", 32'(out_ready), 32'(mq.size() < 2));
            if (mq.size() != 0) begin
                check("o_result",   out_result,          mq[0].result);
                check("o_rd",       32'(out_rd),         32'(mq[0].rd));
                check("o_rd_write", 32'(out_rd_write),   32'(mq[0].wr));
            end
            model_lookup(m_hit, m_val);
            check("lookup_hit",   32'(lookup_hit), 32'(m_hit));
            check("lookup_value", lookup_value,    m_val);
        end
    end

    // Advance one clock and update the model from the inputs sampled at it.
    task automatic tick();
        int  n;
        bit  push, pop;
        @(posedge clk);
        n = mq.size();
        if (rst || flush) begin
            mq.delete();
        end else begin
            push = in_valid && (n < 2);
            pop  = (n > 0) && in_ready;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back('{in_result, in_rd, in_rd_write});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] r,
                         input logic [4:0] d, input logic w, input logic rdy);
        in_valid    = v;
        in_result   = r;
        in_rd       = d;
        in_rd_write = w;
        in_ready    = rdy;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lookup_rs = 5'd0;
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_ready", 32'(out_ready),  32'd1);
        check("rst_hit",   32'(lookup_hit), 32'd0);

        // Single push with downstream ready.
        drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_result", out_result,    32'h1234);
        check("single_rd",    32'(out_rd),    32'd5);
        tick(); #1;
        check("single_gone", 32'(out_valid), 32'd0);

        // Backpressure: fill, then drain in order.
        drive(1'b1, 32'hA, 5'd1, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hB, 5'd2, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        check("full_ready", 32'(out_ready), 32'd0);
        check("full_head",  out_result,     32'hA);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick(); #1;
        check("drain1_head",  out_result,     32'hB);
        check("drain1_ready", 32'(out_ready), 32'd1);
        tick(); #1;
        check("drain2_empty", 32'(out_valid), 32'd0);

        // Streaming: one entry per cycle, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            lookup_rs = 5'(i);
            drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b1);
            tick(); #1;
            check("stream_valid",  32'(out_valid), 32'd1);
            check("stream_result", out_result,     32'(i));
            check("stream_ready",  32'(out_ready), 32'd1);
        end
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick();

        // Lookup: youngest of two matching entries wins.
        drive(1'b1, 32'h11, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h22, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        lookup_rs = 5'd3; #1;
        check("lk_young_hit", 32'(lookup_hit), 32'd1);
        check("lk_young_val", lookup_value,    32'h22);
        lookup_rs = 5'd5; #1;
        check("lk_miss_hit", 32'(lookup_hit), 32'd0);
        check("lk_miss_val", lookup_value,    32'd0);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick(); tick();

        // Lookup: only the older entry matches.
        drive(1'b1, 32'h11, 5'd3, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h22, 5'd4, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        lookup_rs = 5'd3; #1;
        check("lk_old_val", lookup_value, 32'h11);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick(); tick();

        // rd=0 entry passes through but never hits.
        drive(1'b1, 32'h77, 5'd0, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        lookup_rs = 5'd0; #1;
        check("rd0_hit",  32'(lookup_hit),   32'd0);
        check("rd0_rd",   32'(out_rd),       32'd0);
        check("rd0_wr",   32'(out_rd_write), 32'd1);
        check("rd0_res",  out_result,        32'h77);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick();

        // rd_write=0 entry never hits.
        drive(1'b1, 32'h99, 5'd7, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        lookup_rs = 5'd7; #1;
        check("nowr_hit", 32'(lookup_hit), 32'd0);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1); tick();

        // Flush while full, with input valid and downstream ready.
        drive(1'b1, 32'h33, 5'd9, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h44, 5'd9, 1'b1, 1'b0); tick();
        drive(1'b1, 32'hEE, 5'd9, 1'b1, 1'b1);
        flush = 1'b1;
        lookup_rs = 5'd9; #1;
        check("preflush_hit", 32'(lookup_hit), 32'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        #1;
        check("flush_valid", 32'(out_valid),  32'd0);
        check("flush_ready", 32'(out_ready),  32'd1);
        check("flush_hit",   32'(lookup_hit), 32'd0);
        tick(); tick(); #1;
        check("flush_stay_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle with two entries.
        drive(1'b1, 32'h61, 5'd10, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h62, 5'd11, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        mq.delete();
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(out_ready), 32'd1);
        rst = 1'b0;
        tick();
        drive(1'b1, 32'h55, 5'd12, 1'b1, 1'b1); tick();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        #1;
        check("post_rst_valid",  32'(out_valid), 32'd1);
        check("post_rst_result", out_result,     32'h55);
        tick(); #1;
        check("post_rst_alone", 32'(out_valid), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
